// File: rtl/i2c_gpio_read_sequencer.sv
// Passive I2C observer that feeds a one-byte GPIO expander from a frozen
// multi-byte snapshot, one byte per read, and reports completed writes.
module i2c_gpio_read_sequencer #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h0,
    parameter int         N_BYTES     = 4,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         scl_in,
    input  logic                         sda_in,
    input  logic [8*N_BYTES-1:0]         snap_data,
    input  logic [7:0]                   gpio_out_byte,
    output logic [7:0]                   gpio_in_byte,
    output logic [$clog2(N_BYTES)-1:0]   rd_index,
    output logic                         snap_strobe,
    output logic                         wr_strobe,
    output logic [7:0]                   wr_data,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int IDX_W  = $clog2(N_BYTES);
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        WAIT_STOP
    } state_t;

    logic scl_m, scl_s, scl_h;
    logic sda_m, sda_s, sda_h;
    logic start_ev, stop_ev, rise_ev, edge_ev, sda_q;

    state_t              state;
    logic [3:0]          bit_cnt;
    logic [7:0]          shift;
    logic                match;
    logic                rw;
    logic                wr_pend;
    logic [TCNT_W-1:0]   tcnt;
    logic [7:0]          shadow [N_BYTES];
    logic [IDX_W-1:0]    idx_next;

    // Sync flops idle at 1 so reset release never looks like a START.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_m    <= 1'b1;
            scl_s    <= 1'b1;
            scl_h    <= 1'b1;
            sda_m    <= 1'b1;
            sda_s    <= 1'b1;
            sda_h    <= 1'b1;
            start_ev <= 1'b0;
            stop_ev  <= 1'b0;
            rise_ev  <= 1'b0;
            edge_ev  <= 1'b0;
            sda_q    <= 1'b1;
        end else begin
            scl_m    <= scl_in;
            scl_s    <= scl_m;
            scl_h    <= scl_s;
            sda_m    <= sda_in;
            sda_s    <= sda_m;
            sda_h    <= sda_s;
            start_ev <= scl_s & scl_h & sda_h & ~sda_s;
            stop_ev  <= scl_s & scl_h & ~sda_h & sda_s;
            rise_ev  <= scl_s & ~scl_h;
            edge_ev  <= scl_s ^ scl_h;
            sda_q    <= sda_s;
        end
    end

    assign idx_next = (rd_index == IDX_W'(N_BYTES - 1)) ? '0
                    : rd_index + IDX_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= 4'd0;
            shift       <= 8'd0;
            match       <= 1'b0;
            rw          <= 1'b0;
            wr_pend     <= 1'b0;
            tcnt        <= '0;
            rd_index    <= '0;
            snap_strobe <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_data     <= 8'd0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            for (int k = 0; k < N_BYTES; k++) shadow[k] <= 8'd0;
        end else begin
            snap_strobe <= 1'b0;
            wr_strobe   <= 1'b0;
            timeout_err <= 1'b0;
            if (stop_ev) begin
                state <= IDLE;
                busy  <= 1'b0;
                tcnt  <= '0;
                if (wr_pend) begin
                    wr_data   <= gpio_out_byte;
                    wr_strobe <= 1'b1;
                    rd_index  <= '0;
                    wr_pend   <= 1'b0;
                end
            end else if (start_ev) begin
                state   <= ADDR;
                busy    <= 1'b1;
                bit_cnt <= 4'd0;
                shift   <= 8'd0;
                tcnt    <= '0;
                // Freeze a coherent copy only at the head of a sequence.
                if (rd_index == '0) begin
                    for (int k = 0; k < N_BYTES; k++)
                        shadow[k] <= snap_data[8*k +: 8];
                    snap_strobe <= 1'b1;
                end
            end else if (state != IDLE && tcnt == TCNT_W'(TIMEOUT_CYC)) begin
                state       <= IDLE;
                busy        <= 1'b0;
                tcnt        <= '0;
                rd_index    <= '0;
                wr_pend     <= 1'b0;
                timeout_err <= 1'b1;
            end else begin
                if (state == IDLE || edge_ev) tcnt <= '0;
                else                          tcnt <= tcnt + TCNT_W'(1);
                if (rise_ev) begin
                    unique case (state)
                        ADDR: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                state   <= (match && !sda_q) ? DATA : WAIT_STOP;
                            end else begin
                                shift   <= {shift[6:0], sda_q};
                                bit_cnt <= bit_cnt + 4'd1;
                                if (bit_cnt == 4'd7) begin
                                    match <= (shift[6:0] == SLAVE_ADDR);
                                    rw    <= sda_q;
                                end
                            end
                        end
                        DATA: begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt <= 4'd0;
                                state   <= WAIT_STOP;
                                if (rw) rd_index <= idx_next;
                                else    wr_pend  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) gpio_in_byte <= 8'd0;
        else          gpio_in_byte <= shadow[rd_index];
    end

endmodule
